// File: rtl/pixel_tick_gen_if.sv
// Control/status bundle for pixel_tick_gen: divisor programming in,
// tick and period status out.
interface pixel_tick_gen_if #(
  parameter int CNT_W  = 8,
  parameter int FRAC_W = 8
);
  logic              en;
  logic              sync_clr;
  logic              load;
  logic [CNT_W-1:0]  div_in;
  logic [FRAC_W-1:0] frac_in;
  logic              tick;
  logic [CNT_W-1:0]  phase;
  logic [CNT_W-1:0]  div_cur;
  logic              load_pend;
  logic              load_err;

  modport master (
    output en, sync_clr, load, div_in, frac_in,
    input  tick, phase, div_cur, load_pend, load_err
  );

  modport slave (
    input  en, sync_clr, load, div_in, frac_in,
    output tick, phase, div_cur, load_pend, load_err
  );
endinterface

// File: rtl/pixel_tick_gen.sv
// Programmable pixel tick generator: integer divisor N plus a fractional
// accumulator that stretches selected periods to N+1 cycles. New settings
// are staged and only take effect at a period boundary or on sync_clr.
module pixel_tick_gen #(
  parameter int CNT_W        = 8,
  parameter int FRAC_W       = 8,
  parameter int DIV_DEFAULT  = 4,
  parameter int FRAC_DEFAULT = 0
) (
  input  logic             clk,
  input  logic             rst,
  pixel_tick_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0]  DIV_RST  = CNT_W'(DIV_DEFAULT);
  localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(FRAC_DEFAULT);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FRAC_W-1:0] FRAC_ZERO = {FRAC_W{1'b0}};

  logic [CNT_W-1:0]  count_q, count_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              tick_q, tick_d;
  logic              load_pend_q, load_pend_d;
  logic              load_err_q, load_err_d;
  logic [CNT_W-1:0]  div_cur_q, div_cur_d;
  logic [FRAC_W-1:0] frac_cur_q, frac_cur_d;
  logic [CNT_W-1:0]  stg_div_q, stg_div_d;
  logic [FRAC_W-1:0] stg_frac_q, stg_frac_d;

  logic [FRAC_W:0]   sum_s;
  logic [CNT_W-1:0]  div_last_s;
  logic              apply_s;

  // Next-state: phase counting, fractional stretch, apply point and load staging.
  always_comb begin
    sum_s       = {1'b0, acc_q} + {1'b0, frac_cur_q};
    div_last_s  = div_cur_q - CNT_ONE;
    count_d     = count_q;
    acc_d       = acc_q;
    tick_d      = 1'b0;
    load_pend_d = load_pend_q;
    load_err_d  = 1'b0;
    div_cur_d   = div_cur_q;
    frac_cur_d  = frac_cur_q;
    stg_div_d   = stg_div_q;
    stg_frac_d  = stg_frac_q;
    apply_s     = 1'b0;

    if (bus.sync_clr) begin
      // Phase restart; a pending setting is applied right away.
      count_d = CNT_ZERO;
      acc_d   = FRAC_ZERO;
      apply_s = load_pend_q;
    end else if (bus.en) begin
      if (count_q >= div_cur_q) begin
        // Extended (N+1-th) cycle ends the period without touching acc.
        count_d = CNT_ZERO;
        tick_d  = 1'b1;
        apply_s = load_pend_q;
      end else if (count_q == div_last_s) begin
        acc_d = sum_s[FRAC_W-1:0];
        if (sum_s[FRAC_W]) begin
          // Carry out: stretch this period by one cycle.
          count_d = div_cur_q;
        end else begin
          count_d = CNT_ZERO;
          tick_d  = 1'b1;
          apply_s = load_pend_q;
        end
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      // Disabled: counting state frozen, tick stays low.
      count_d = count_q;
      acc_d   = acc_q;
    end

    // Apply happens before staging so a same-cycle load remains pending.
    if (apply_s) begin
      div_cur_d   = stg_div_q;
      frac_cur_d  = stg_frac_q;
      load_pend_d = 1'b0;
    end else begin
      div_cur_d  = div_cur_q;
      frac_cur_d = frac_cur_q;
    end

    if (bus.load) begin
      if (bus.div_in == CNT_ZERO) begin
        load_err_d = 1'b1;
      end else begin
        stg_div_d   = bus.div_in;
        stg_frac_d  = bus.frac_in;
        load_pend_d = 1'b1;
      end
    end else begin
      stg_div_d  = stg_div_q;
      stg_frac_d = stg_frac_q;
    end
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= CNT_ZERO;
      acc_q       <= FRAC_ZERO;
      tick_q      <= 1'b0;
      load_pend_q <= 1'b0;
      load_err_q  <= 1'b0;
      div_cur_q   <= DIV_RST;
      frac_cur_q  <= FRAC_RST;
      stg_div_q   <= CNT_ZERO;
      stg_frac_q  <= FRAC_ZERO;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      tick_q      <= tick_d;
      load_pend_q <= load_pend_d;
      load_err_q  <= load_err_d;
      div_cur_q   <= div_cur_d;
      frac_cur_q  <= frac_cur_d;
      stg_div_q   <= stg_div_d;
      stg_frac_q  <= stg_frac_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.phase     = count_q;
  assign bus.div_cur   = div_cur_q;
  assign bus.load_pend = load_pend_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_pixel_tick_gen.sv
// Directed, table-driven bench for pixel_tick_gen with hand-computed
// expectations and a few multi-cycle sequences.
module tb_pixel_tick_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  pixel_tick_gen_if #(.CNT_W(8), .FRAC_W(8)) ifc ();

  pixel_tick_gen #(
    .CNT_W(8), .FRAC_W(8), .DIV_DEFAULT(4), .FRAC_DEFAULT(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       sclr;
    logic       load;
    logic [7:0] div;
    logic [7:0] frac;
    logic       tick;
    logic [7:0] phase;
    logic [7:0] divc;
    logic       pend;
    logic       err;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic e, input logic s, input logic l,
                     input logic [7:0] d, input logic [7:0] f,
                     input logic t, input logic [7:0] p, input logic [7:0] dc,
                     input logic pd, input logic er);
    vec_t v;
    v.rst = r; v.en = e; v.sclr = s; v.load = l; v.div = d; v.frac = f;
    v.tick = t; v.phase = p; v.divc = dc; v.pend = pd; v.err = er;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic e, input logic s, input logic l,
                     input logic [7:0] d, input logic [7:0] f);
    @(negedge clk);
    rst = 1'b1; ifc.en = e; ifc.sync_clr = s; ifc.load = l;
    ifc.div_in = d; ifc.frac_in = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nt;
    int last;
    ifc.en = 1'b0; ifc.sync_clr = 1'b0; ifc.load = 1'b0;
    ifc.div_in = 8'd0; ifc.frac_in = 8'd0;

    // rst en sc ld div frac | tick phase divc pend err
    add(0,0,0,0,8'd0,8'd0, 0,8'd0,8'd4,0,0);
    add(0,0,0,0,8'd0,8'd0, 0,8'd0,8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 0,8'd1,8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 0,8'd2,8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 0,8'd3,8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 1,8'd0,8'd4,0,0);
    add(1,1,0,1,8'd0,8'd0, 0,8'd1,8'd4,0,1);   // rejected load
    add(1,1,0,0,8'd0,8'd0, 0,8'd2,8'd4,0,0);
    for (int i = 0; i < 5; i++) add(1,0,0,0,8'd0,8'd0, 0,8'd2,8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 0,8'd3,8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 1,8'd0,8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 0,8'd1,8'd4,0,0);
    add(1,1,0,1,8'd6,8'd0, 0,8'd2,8'd4,1,0);   // mid-period load N=6
    add(1,1,0,0,8'd0,8'd0, 0,8'd3,8'd4,1,0);
    add(1,1,0,0,8'd0,8'd0, 1,8'd0,8'd6,0,0);
    for (int i = 1; i <= 5; i++) add(1,1,0,0,8'd0,8'd0, 0,8'(i),8'd6,0,0);
    add(1,1,0,0,8'd0,8'd0, 1,8'd0,8'd6,0,0);
    add(1,1,0,1,8'd4,8'd0, 0,8'd1,8'd6,1,0);   // back to N=4
    for (int i = 2; i <= 5; i++) add(1,1,0,0,8'd0,8'd0, 0,8'(i),8'd6,1,0);
    add(1,1,0,0,8'd0,8'd0, 1,8'd0,8'd4,0,0);
    for (int i = 1; i <= 3; i++) add(1,1,0,0,8'd0,8'd0, 0,8'(i),8'd4,0,0);
    add(0,1,0,1,8'd9,8'd0, 0,8'd0,8'd4,0,0);   // reset with load at phase 3
    for (int i = 1; i <= 3; i++) add(1,1,0,0,8'd0,8'd0, 0,8'(i),8'd4,0,0);
    add(1,1,0,0,8'd0,8'd0, 1,8'd0,8'd4,0,0);

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; ifc.en = tv[i].en; ifc.sync_clr = tv[i].sclr;
      ifc.load = tv[i].load; ifc.div_in = tv[i].div; ifc.frac_in = tv[i].frac;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.tick", i),    32'(ifc.tick),      32'(tv[i].tick));
      chk($sformatf("v%0d.phase", i),   32'(ifc.phase),     32'(tv[i].phase));
      chk($sformatf("v%0d.div_cur", i), 32'(ifc.div_cur),   32'(tv[i].divc));
      chk($sformatf("v%0d.pend", i),    32'(ifc.load_pend), 32'(tv[i].pend));
      chk($sformatf("v%0d.err", i),     32'(ifc.load_err),  32'(tv[i].err));
    end

    // Load landing on the apply edge is staged for the following boundary.
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("seqc.phase", 32'(ifc.phase), 32'(i));
    end
    cyc(1'b1, 1'b0, 1'b1, 8'd2, 8'd0);
    chk("seqc.tick0", 32'(ifc.tick), 32'd1);
    chk("seqc.div_old", 32'(ifc.div_cur), 32'd4);
    chk("seqc.pend", 32'(ifc.load_pend), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("seqc.hold_n4", 32'({ifc.tick, ifc.phase}), 32'(i));
    end
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("seqc.tick1", 32'(ifc.tick), 32'd1);
    chk("seqc.div_new", 32'(ifc.div_cur), 32'd2);
    chk("seqc.pend_clr", 32'(ifc.load_pend), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("seqc.n2_p1", 32'({ifc.tick, ifc.phase}), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("seqc.n2_tick", 32'({ifc.tick, ifc.phase}), 32'h100);

    // Fractional N=3, F=0x80 applied by sync_clr: periods 3,4,3,4,...
    cyc(1'b1, 1'b0, 1'b1, 8'd3, 8'h80);
    chk("seqa.pend", 32'(ifc.load_pend), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    chk("seqa.sync_div", 32'(ifc.div_cur), 32'd3);
    chk("seqa.sync_pend", 32'(ifc.load_pend), 32'd0);
    chk("seqa.sync_state", 32'({ifc.tick, ifc.phase}), 32'd0);
    nt = 0;
    last = 0;
    for (int c = 1; c <= 80 && nt < 10; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      if (ifc.tick) begin
        nt++;
        chk($sformatf("seqa.period%0d", nt), 32'(c - last), (nt % 2 == 1) ? 32'd3 : 32'd4);
        last = c;
      end
    end
    chk("seqa.ticks", 32'(nt), 32'd10);
    chk("seqa.span", 32'(last), 32'd35);

    // N=1, F=0: tick held high continuously while enabled.
    cyc(1'b1, 1'b0, 1'b1, 8'd1, 8'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    chk("seqb.sync_tick", 32'(ifc.tick), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("seqb.tick_phase", 32'({ifc.tick, ifc.phase}), 32'h100);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("seqb.en_low", 32'(ifc.tick), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
